// File: rtl/sar_ctrl_mc.sv
// SAR ADC controller: start/busy/eoc handshake, channel mux with single-shot or round-robin
// scan, configurable sample window. Optional result averaging under `SAR_AVG_EN.
module sar_ctrl_mc #(
   parameter int unsigned ADC_RESOLUTION = 10,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned SAMPLE_CYCLES  = 2,
   parameter int unsigned AVG_LOG2       = 2,
   localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic                      i_start,
   input  logic [CW-1:0]             i_chan,
   input  logic                      i_scan,
   input  logic                      i_abort,
   input  logic                      i_comp,
   output logic                      o_busy,
   output logic                      o_sample,
   output logic [CW-1:0]             o_mux_sel,
   output logic [ADC_RESOLUTION-1:0] o_dac_code,
   output logic                      o_eoc,
   output logic [ADC_RESOLUTION-1:0] o_data,
   output logic [CW-1:0]             o_data_chan,
   output logic                      o_err
);

   localparam int unsigned RW = ADC_RESOLUTION;
   localparam int unsigned SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int unsigned BW = (ADC_RESOLUTION > 1) ? $clog2(ADC_RESOLUTION) : 1;

   if (NUM_CH < 1 || SAMPLE_CYCLES < 1 || ADC_RESOLUTION < 1 || AVG_LOG2 > 16) begin : g_bad_params
      $error("sar_ctrl_mc: invalid parameter set");
   end

   typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_chan;
   logic [SW-1:0] r_scnt;
   logic [BW-1:0] r_bit;
   logic [RW-1:0] r_code;
   logic [RW-1:0] r_data;
   logic [CW-1:0] r_data_chan;
   logic          r_err;

   logic          w_chan_ok;
   logic          w_samp_done;
   logic          w_last_bit;
   logic          w_conv_end;
   logic          w_repeat;
   logic [CW-1:0] w_chan_inc;
   logic [CW-1:0] w_chan_nxt;
   logic [RW-1:0] w_result;

   assign w_chan_ok   = (32'(i_chan) < NUM_CH);
   assign w_samp_done = (r_scnt == SW'(SAMPLE_CYCLES - 1));
   assign w_last_bit  = (r_bit == '0);
   assign w_conv_end  = (r_state == StConvert) && w_last_bit && !i_abort;
   assign w_chan_inc  = (r_chan == CW'(NUM_CH - 1)) ? '0 : r_chan + 1'b1;
   // Bit 0 is still on the comparator input at the edge that ends the conversion.
   assign w_result    = r_code | RW'(i_comp);

`ifdef SAR_AVG_EN
   localparam int unsigned AW    = RW + AVG_LOG2;
   localparam int unsigned NW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned AVG_N = 1 << AVG_LOG2;

   logic [AW-1:0] r_acc;
   logic [NW-1:0] r_avg_cnt;
   logic [AW-1:0] w_acc_sum;
   logic          w_avg_last;
   logic          w_avg_final;

   assign w_acc_sum   = r_acc + AW'(w_result);
   assign w_avg_last  = (r_avg_cnt == NW'(AVG_N - 1));
   // Counter wraps to zero on the last conversion, so zero in DONE marks a finished result.
   assign w_avg_final = (r_avg_cnt == '0);
   assign w_repeat    = i_scan || !w_avg_final;
   assign w_chan_nxt  = w_avg_final ? w_chan_inc : r_chan;
   assign o_eoc       = (r_state == StDone) && w_avg_final;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_acc       <= '0;
         r_avg_cnt   <= '0;
         r_data      <= '0;
         r_data_chan <= '0;
      end else if (i_abort) begin
         r_acc     <= '0;
         r_avg_cnt <= '0;
      end else if (w_conv_end) begin
         if (w_avg_last) begin
            r_acc       <= '0;
            r_avg_cnt   <= '0;
            r_data      <= w_acc_sum[AW-1:AVG_LOG2];
            r_data_chan <= r_chan;
         end else begin
            r_acc     <= w_acc_sum;
            r_avg_cnt <= r_avg_cnt + 1'b1;
         end
      end
   end
`else
   assign w_repeat   = i_scan;
   assign w_chan_nxt = w_chan_inc;
   assign o_eoc      = (r_state == StDone);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_data      <= '0;
         r_data_chan <= '0;
      end else if (w_conv_end) begin
         r_data      <= w_result;
         r_data_chan <= r_chan;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:    if (i_start && w_chan_ok) w_state_nxt = StSample;
         StSample:  if (w_samp_done) w_state_nxt = StConvert;
         StConvert: if (w_last_bit) w_state_nxt = StDone;
         StDone:    w_state_nxt = w_repeat ? StSample : StIdle;
         default:   w_state_nxt = StIdle;
      endcase
      if (i_abort) w_state_nxt = StIdle;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= StIdle;
         r_chan  <= '0;
         r_scnt  <= '0;
         r_bit   <= '0;
         r_code  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= (r_state == StIdle) && i_start && !w_chan_ok && !i_abort;
         unique case (r_state)
            StIdle: begin
               r_scnt <= '0;
               if (w_state_nxt == StSample) r_chan <= i_chan;
            end
            StSample: begin
               r_scnt <= r_scnt + 1'b1;
               r_bit  <= BW'(RW - 1);
               r_code <= '0;
            end
            StConvert: begin
               r_code[r_bit] <= i_comp;
               r_bit         <= r_bit - 1'b1;
            end
            StDone: begin
               r_scnt <= '0;
               if (w_state_nxt == StSample) r_chan <= w_chan_nxt;
            end
            default: r_scnt <= '0;
         endcase
      end
   end

   assign o_busy      = (r_state != StIdle);
   assign o_sample    = (r_state == StSample);
   assign o_mux_sel   = r_chan;
   assign o_dac_code  = (r_state == StConvert) ? (r_code | (RW'(1) << r_bit)) : '0;
   assign o_data      = r_data;
   assign o_data_chan = r_data_chan;
   assign o_err       = r_err;

endmodule
